// File: rtl/datapath_trace_unit_pkg.sv
// Shared definitions for the datapath trace unit: capture modes, FSM states
// and the trace entry width helper.
package datapath_trace_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ALL    = 1'b0;
  localparam logic MODE_CHANGE = 1'b1;

  function automatic int entry_width(input int cyc_w, input int xlen, input int num_watch);
    return cyc_w + xlen + num_watch * xlen;
  endfunction

endpackage

// File: rtl/datapath_trace_unit_fifo.sv
// Synchronous trace FIFO with flush; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != (AW+1)'(0));
  assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == (AW+1)'(0));

endmodule

// File: rtl/datapath_trace_unit.sv
// Cycle tracer beside the datapath: snapshots PC and watched registers each
// advancing cycle into a drainable FIFO, halting after MAX_CYCLES traced cycles.
module datapath_trace_unit
  import datapath_trace_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_WATCH  = 7,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 15,
  parameter int CYC_W      = 16
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_start,
  input  logic                                         i_mode,
  input  logic                                         i_en,
  input  logic [XLEN-1:0]                              i_pc_in,
  input  logic [NUM_WATCH*XLEN-1:0]                    i_watch_in,
  output logic                                         o_tr_valid,
  input  logic                                         i_tr_ready,
  output logic [entry_width(CYC_W, XLEN, NUM_WATCH)-1:0] o_tr_data,
  output logic                                         o_halt,
  output logic                                         o_busy,
  output logic                                         o_overflow,
  output logic [CYC_W-1:0]                             o_drop_cnt
);

  localparam int EW = entry_width(CYC_W, XLEN, NUM_WATCH);
  localparam int WW = NUM_WATCH * XLEN;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CYC_W-1:0] r_cyc;
  logic             r_mode;
  logic [WW-1:0]    r_last;
  logic             r_first;
  logic             r_halt;
  logic             r_busy;
  logic             r_overflow;
  logic [CYC_W-1:0] r_drop_cnt;

  logic             w_capture;
  logic             w_changed;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [EW-1:0]    w_rdata;

  // A restart pulse takes the cycle, so capture is suppressed while start is high
  assign w_capture = (r_state == ST_RUN) & i_en & ~i_start;
  assign w_changed = (r_mode != MODE_CHANGE) | r_first | (i_watch_in != r_last);
  assign w_push    = w_capture & w_changed;
  assign w_pop     = ~w_empty & i_tr_ready;
  assign w_drop    = w_push & w_full & ~w_pop;

  // Next-state decode for the run controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else if (i_en && (r_cyc == LAST_CYC)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered halt/busy decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_halt  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_halt  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  // Traced-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc <= '0;
    end else if (i_start) begin
      r_cyc <= '0;
    end else if (w_capture) begin
      r_cyc <= r_cyc + CYC_ONE;
    end else begin
      r_cyc <= r_cyc;
    end
  end

  // Mode latch and change-detect snapshot; snapshot follows every candidate
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode  <= 1'b0;
      r_last  <= '0;
      r_first <= 1'b0;
    end else if (i_start) begin
      r_mode  <= i_mode;
      r_last  <= '0;
      r_first <= 1'b1;
    end else if (w_capture) begin
      r_mode  <= r_mode;
      r_last  <= i_watch_in;
      r_first <= 1'b0;
    end else begin
      r_mode  <= r_mode;
      r_last  <= r_last;
      r_first <= r_first;
    end
  end

  // Drop accounting, saturating at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != {CYC_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + CYC_ONE;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end else begin
      r_overflow <= r_overflow;
      r_drop_cnt <= r_drop_cnt;
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_cyc, i_pc_in, i_watch_in}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_tr_valid = ~w_empty;
  assign o_tr_data  = w_rdata;
  assign o_halt     = r_halt;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_datapath_trace_unit.sv
// Scoreboard bench for datapath_trace_unit: directed runs with hand-built
// expected entries; a second instance with a longer run covers overflow.
module tb_datapath_trace_unit;
  import datapath_trace_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int NW    = 7;
  localparam int DEPTH = 16;
  localparam int CYC_W = 16;
  localparam int WW    = NW * XLEN;
  localparam int EW    = CYC_W + XLEN + WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, mode, en, ready1, ready2;
  logic [XLEN-1:0] pc;
  logic [WW-1:0]   watch;
  logic            v1, h1, b1, o1, v2, h2, b2, o2;
  logic [EW-1:0]   d1, d2;
  logic [CYC_W-1:0] dc1, dc2;

  datapath_trace_unit #(.XLEN(XLEN), .NUM_WATCH(NW), .DEPTH(DEPTH), .MAX_CYCLES(15), .CYC_W(CYC_W)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_en(en),
    .i_pc_in(pc), .i_watch_in(watch), .o_tr_valid(v1), .i_tr_ready(ready1),
    .o_tr_data(d1), .o_halt(h1), .o_busy(b1), .o_overflow(o1), .o_drop_cnt(dc1));

  datapath_trace_unit #(.XLEN(XLEN), .NUM_WATCH(NW), .DEPTH(DEPTH), .MAX_CYCLES(20), .CYC_W(CYC_W)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_en(en),
    .i_pc_in(pc), .i_watch_in(watch), .o_tr_valid(v2), .i_tr_ready(ready2),
    .o_tr_data(d2), .o_halt(h2), .o_busy(b2), .o_overflow(o2), .o_drop_cnt(dc2));

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [WW-1:0] pat(input int seed);
    logic [WW-1:0] w;
    for (int k = 0; k < NW; k++) w[k*XLEN +: XLEN] = {8'(k+1), 8'h5A, 16'(seed)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one clock with en=1; optionally record the entry dut1 should emit
  task automatic cap(input int c, input logic [XLEN-1:0] p, input logic [WW-1:0] w, input bit expect1);
    en = 1'b1; pc = p; watch = w;
    if (expect1) exp_q.push_back({16'(c), p, w});
    step();
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m; en = 1'b1; pc = 32'hDEAD_BEEF; watch = pat(999);
    step();
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    en = 1'b0;
    while ((exp_q.size() != 0 || v1) && t < 100) begin
      step();
      t++;
    end
    chk(name, {63'd0, (exp_q.size() == 0 && !v1)}, 64'd1);
  endtask

  // Monitor: every dut1 handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && v1 && ready1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_entry: got %h expected none", d1);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (d1 !== e) begin
          n_bad++;
          $display("FAIL entry: got %h expected %h", d1, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; en = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
    pc = '0; watch = '0;
    step(); step();
    chk("rst_valid", {63'd0, v1}, 64'd0);
    chk("rst_busy", {63'd0, b1}, 64'd0);
    chk("rst_halt", {63'd0, h1}, 64'd0);
    chk("rst_ovf", {63'd0, o1}, 64'd0);
    chk("rst_drop", {48'd0, dc1}, 64'd0);
    rst = 1'b0; ready1 = 1'b1; ready2 = 1'b1;

    // 1: capture-all, consumer always ready
    do_start(1'b0);
    chk("t1_busy", {63'd0, b1}, 64'd1);
    for (int c = 0; c < 15; c++) begin
      if (c == 14) chk("t1_halt_early", {63'd0, h1}, 64'd0);
      cap(c, 32'(4*c), pat(c), 1'b1);
    end
    chk("t1_halt", {62'd0, h1, b1}, 64'd2);
    for (int c = 0; c < 3; c++) cap(0, 32'h0BAD_0000, pat(500), 1'b0);
    chk("t1_halt_sticky", {63'd0, h1}, 64'd1);
    drain("t1_drain");

    // 2: consumer stalled; dut2 runs 20 cycles into a 16-deep FIFO
    ready1 = 1'b0; ready2 = 1'b0;
    do_start(1'b0);
    for (int c = 0; c < 20; c++) cap(c, 32'(32'h100 + 4*c), pat(c + 100), c < 15);
    chk("t2_d1_flags", {60'd0, v1, h1, o1, (dc1 == 16'd0)}, 64'b1101);
    chk("t2_d2_ovf", {63'd0, o2}, 64'd1);
    chk("t2_d2_drop", {48'd0, dc2}, 64'd4);
    ready1 = 1'b1; ready2 = 1'b1; en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("t2_d2_entry", {15'd0, v2, d2[EW-1 -: CYC_W], d2[EW-CYC_W-1 -: XLEN]},
          {15'd0, 1'b1, 16'(k), 32'(32'h100 + 4*k)});
      step();
    end
    chk("t2_d2_empty", {63'd0, v2}, 64'd0);
    drain("t2_drain");

    // 3: change-only capture, x3 changes at cycles 2 and 5
    do_start(1'b1);
    for (int c = 0; c < 15; c++) begin
      logic [WW-1:0] w;
      w = pat(16'h77);
      w[2*XLEN +: XLEN] = (c < 2) ? 32'h3333_0000 : (c < 5) ? 32'h3333_0002 : 32'h3333_0005;
      cap(c, 32'(32'h200 + 4*c), w, (c == 0) || (c == 2) || (c == 5));
    end
    chk("t3_halt", {63'd0, h1}, 64'd1);
    drain("t3_drain");

    // 4: en alternates; only en-high clocks are traced
    do_start(1'b0);
    for (int t = 0; t < 30; t++) begin
      if (t == 28) chk("t4_halt_early", {63'd0, h1}, 64'd0);
      if (t % 2 == 0) begin
        cap(t / 2, 32'(32'h300 + 4*t), pat(t), 1'b1);
      end else begin
        en = 1'b0; pc = 32'(32'h300 + 4*t); watch = pat(t);
        step();
      end
    end
    chk("t4_halt", {62'd0, h1, b1}, 64'd2);
    drain("t4_drain");

    // 5: dut2 fills, then pops while capturing; no drops, order preserved
    ready2 = 1'b0;
    do_start(1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c == 16) begin
        chk("t5_full_valid", {63'd0, v2}, 64'd1);
        ready2 = 1'b1;
      end
      cap(c, 32'(32'h400 + 4*c), pat(c + 200), c < 15);
    end
    chk("t5_no_drop", {47'd0, o2, dc2}, 64'd0);
    en = 1'b0;
    for (int k = 4; k < 20; k++) begin
      chk("t5_d2_entry", {47'd0, v2, d2[EW-1 -: CYC_W]}, {47'd0, 1'b1, 16'(k)});
      step();
    end
    chk("t5_d2_empty", {63'd0, v2}, 64'd0);
    drain("t5_drain");

    // 6: reset in the middle of a run, then a fresh run and a mid-run restart
    ready1 = 1'b0; ready2 = 1'b0;
    do_start(1'b0);
    for (int c = 0; c < 7; c++) cap(c, 32'(32'h500 + 4*c), pat(c + 300), 1'b0);
    rst = 1'b1; en = 1'b1;
    step();
    chk("t6_after_rst", {59'd0, v1, b1, h1, o1, (dc1 != 16'd0)}, 64'd0);
    chk("t6_d2_after_rst", {63'd0, v2}, 64'd0);
    rst = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
    do_start(1'b0);
    for (int c = 0; c < 3; c++) cap(c, 32'(32'h600 + 4*c), pat(c + 400), 1'b1);
    drain("t6_drain");
    chk("t6_busy_mid", {63'd0, b1}, 64'd1);
    do_start(1'b0);
    for (int c = 0; c < 2; c++) cap(c, 32'(32'h700 + 4*c), pat(c + 500), 1'b1);
    drain("t6_restart_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
